// File: rtl/sobel_window_ctrl.sv
// Window/validation controller after the sobel filter: border masking, thresholding, frame lock.
// Optional per-frame statistics ports enabled by defining SOBEL_WINDOW_CTRL_STATS_EN.
module sobel_window_ctrl #(
   parameter int H_SIZE    = 83,
   parameter int MIN_LINES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [7:0] threshold,
   input  logic [7:0] in_sobel,
   input  logic       in_de,
   input  logic       in_hsync,
   input  logic       in_vsync,
   output logic [7:0] out_edge,
   output logic       out_de,
   output logic       out_hsync,
   output logic       out_vsync,
   output logic       locked,
   output logic       err_width,
   output logic [9:0] meas_lines
`ifdef SOBEL_WINDOW_CTRL_STATS_EN
   ,
   output logic [19:0] edge_count,
   output logic [15:0] frame_count
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam logic [9:0] H_W    = 10'(H_SIZE);
   localparam logic [9:0] H_LAST = 10'(H_SIZE - 1);
   localparam logic [9:0] MIN_L  = 10'(MIN_LINES);
   localparam logic [9:0] CNT_MAX = '1;

   state_t      state_q, state_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        err_acc_q, err_acc_d;
   logic        err_width_q, err_width_d;
   logic [9:0]  meas_lines_q, meas_lines_d;
   logic [7:0]  thr_q, thr_d;
   logic [7:0]  edge_q, edge_d;
   logic        de_q, hsync_q, vsync_q;

   logic fs, le, good, mask, pass;

`ifdef SOBEL_WINDOW_CTRL_STATS_EN
   logic [19:0] edge_acc_q, edge_acc_d;
   logic [19:0] edge_count_q, edge_count_d;
   logic [15:0] frame_count_q, frame_count_d;
`endif

   always_comb begin
      fs   = in_vsync & ~vsync_q;
      le   = ~in_de & de_q;
      good = ~err_acc_q && (y_q >= MIN_L);

      x_d          = x_q;
      y_d          = y_q;
      err_acc_d    = err_acc_q;
      err_width_d  = err_width_q;
      meas_lines_d = meas_lines_q;
      thr_d        = thr_q;

      if (fs) begin
         x_d          = '0;
         y_d          = '0;
         err_acc_d    = 1'b0;
         err_width_d  = err_acc_q;
         meas_lines_d = y_q;
         thr_d        = threshold;
      end else if (le) begin
         x_d = '0;
         if (y_q != CNT_MAX) y_d = y_q + 10'd1;
         if (x_q != H_W)     err_acc_d = 1'b1;
      end else if (in_de && x_q != CNT_MAX) begin
         x_d = x_q + 10'd1;
      end

      state_d = state_q;
      case (state_q)
         IDLE:    if (fs) state_d = MEASURE;
         MEASURE: if (fs && good) state_d = RUN;
         RUN: begin
            if (fs) state_d = good ? RUN : MEASURE;
            else if (x_q == CNT_MAX) state_d = MEASURE;
         end
         default: state_d = IDLE;
      endcase

      // x/y are pre-increment positions of the current pixel; a frame-start pixel is never valid
      mask = (state_q != RUN) || (x_q == '0) || (x_q == H_LAST) ||
             (y_q == '0) || (y_q == meas_lines_q - 10'd1) || fs;
      pass = (in_sobel >= thr_q);

      if (!enable)                     edge_d = in_sobel;
      else if (in_de && !mask && pass) edge_d = 8'hFF;
      else                             edge_d = 8'h00;
   end

`ifdef SOBEL_WINDOW_CTRL_STATS_EN
   always_comb begin
      edge_acc_d    = edge_acc_q;
      edge_count_d  = edge_count_q;
      frame_count_d = frame_count_q;
      if (fs) begin
         edge_acc_d   = '0;
         edge_count_d = edge_acc_q;
         if (state_q == RUN) frame_count_d = frame_count_q + 16'd1;
      end else if (enable && in_de && !mask && pass && edge_acc_q != '1) begin
         edge_acc_d = edge_acc_q + 20'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_acc_q    <= '0;
         edge_count_q  <= '0;
         frame_count_q <= '0;
      end else begin
         edge_acc_q    <= edge_acc_d;
         edge_count_q  <= edge_count_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign edge_count  = edge_count_q;
   assign frame_count = frame_count_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         err_acc_q    <= 1'b0;
         err_width_q  <= 1'b0;
         meas_lines_q <= '0;
         thr_q        <= 8'h80;
         edge_q       <= '0;
         de_q         <= 1'b0;
         hsync_q      <= 1'b0;
         vsync_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         err_acc_q    <= err_acc_d;
         err_width_q  <= err_width_d;
         meas_lines_q <= meas_lines_d;
         thr_q        <= thr_d;
         edge_q       <= edge_d;
         de_q         <= in_de;
         hsync_q      <= in_hsync;
         vsync_q      <= in_vsync;
      end
   end

   assign out_edge   = edge_q;
   assign out_de     = de_q;
   assign out_hsync  = hsync_q;
   assign out_vsync  = vsync_q;
   assign locked     = (state_q == RUN);
   assign err_width  = err_width_q;
   assign meas_lines = meas_lines_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl with H_SIZE=8, MIN_LINES=3.
module tb_sobel_window_ctrl;

   localparam int H = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [7:0] threshold;
   logic [7:0] in_sobel;
   logic       in_de, in_hsync, in_vsync;
   logic [7:0] out_edge;
   logic       out_de, out_hsync, out_vsync;
   logic       locked, err_width;
   logic [9:0] meas_lines;
`ifdef SOBEL_WINDOW_CTRL_STATS_EN
   logic [19:0] edge_count;
   logic [15:0] frame_count;
`endif

   sobel_window_ctrl #(.H_SIZE(H), .MIN_LINES(3)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .threshold(threshold),
      .in_sobel(in_sobel), .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
      .out_edge(out_edge), .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync),
      .locked(locked), .err_width(err_width), .meas_lines(meas_lines)
`ifdef SOBEL_WINDOW_CTRL_STATS_EN
      , .edge_count(edge_count), .frame_count(frame_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] edge_v;
      logic       de;
      logic       hs;
      logic       vs;
   } exp_t;

   typedef struct {
      logic       en;
      logic [7:0] sobel;
      logic [7:0] exp_edge;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[8];
   int   checks = 0;
   int   passes = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
   endtask

   // One pixel: drive on the falling edge, expected output queued now, compared after the capture edge.
   task automatic px(input logic en, input logic de, input logic hs, input logic vs,
                     input logic [7:0] s, input logic [7:0] e);
      exp_t x;
      exp_t g;
      @(negedge clk);
      enable = en; in_de = de; in_hsync = hs; in_vsync = vs; in_sobel = s;
      x.edge_v = e; x.de = de; x.hs = hs; x.vs = vs;
      sb.push_back(x);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      checks++;
      if (out_edge === g.edge_v && out_de === g.de && out_hsync === g.hs && out_vsync === g.vs)
         passes++;
      else
         $display("FAIL pixel (t=%0t): got edge=%h de=%b hs=%b vs=%b, expected edge=%h de=%b hs=%b vs=%b",
                  $time, out_edge, out_de, out_hsync, out_vsync, g.edge_v, g.de, g.hs, g.vs);
   endtask

   function automatic logic [7:0] exp_px(input bit run, input int x, input int y, input int meas,
                                         input logic [7:0] s, input logic [7:0] thr);
      return (run && x >= 1 && x <= H - 2 && y >= 1 && y != meas - 1 && s >= thr) ? 8'hFF : 8'h00;
   endfunction

   task automatic line(input int w, input int y, input logic [7:0] s, input bit run,
                       input int meas, input logic [7:0] thr);
      repeat (2) px(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      for (int x = 0; x < w; x++) px(1'b1, 1'b1, 1'b0, 1'b0, s, exp_px(run, x, y, meas, s, thr));
      repeat (2) px(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic frame(input int lines, input int short_y, input logic [7:0] s, input bit run,
                        input int meas, input logic [7:0] thr);
      for (int y = 0; y < lines; y++) line((y == short_y) ? H - 1 : H, y, s, run, meas, thr);
   endtask

   // Frame start pulse; status is checked right after the edge that sees the vsync rise.
   task automatic vs_pulse(input logic el, input logic ee, input int em, input int ec, input int fc);
      px(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      check("locked", locked, el);
      check("err_width", err_width, ee);
      check("meas_lines", meas_lines, em);
`ifdef SOBEL_WINDOW_CTRL_STATS_EN
      check("edge_count", edge_count, ec);
      check("frame_count", frame_count, fc);
`endif
      px(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      repeat (2) px(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   initial begin
      tbl[0] = '{1'b0, 8'h35, 8'h35};
      tbl[1] = '{1'b1, 8'h7F, 8'h00};
      tbl[2] = '{1'b1, 8'h80, 8'hFF};
      tbl[3] = '{1'b1, 8'hFF, 8'hFF};
      tbl[4] = '{1'b1, 8'h00, 8'h00};
      tbl[5] = '{1'b0, 8'h35, 8'h35};
      tbl[6] = '{1'b1, 8'h81, 8'hFF};
      tbl[7] = '{1'b1, 8'hC0, 8'h00};

      rst_n = 1'b0; enable = 1'b1; threshold = 8'h80;
      in_sobel = 8'h00; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_edge", out_edge, 8'h00);
      check("reset out_de", out_de, 1'b0);
      check("reset locked", locked, 1'b0);
      check("reset meas_lines", meas_lines, 10'd0);
      check("reset err_width", err_width, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Acquire lock
      vs_pulse(1'b0, 1'b0, 0, 0, 0);
      frame(4, -1, 8'hC0, 1'b0, 4, 8'h80);
      vs_pulse(1'b1, 1'b0, 4, 0, 0);
      frame(4, -1, 8'hC0, 1'b1, 4, 8'h80);
      vs_pulse(1'b1, 1'b0, 4, 12, 1);

      // Threshold boundary and bypass vectors on line 1, then a mid-frame threshold change
      line(H, 0, 8'hC0, 1'b1, 4, 8'h80);
      repeat (2) px(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 8; i++) px(tbl[i].en, 1'b1, 1'b0, 1'b0, tbl[i].sobel, tbl[i].exp_edge);
      repeat (2) px(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("locked after bypass", locked, 1'b1);
      threshold = 8'h90;
      line(H, 2, 8'h80, 1'b1, 4, 8'h80);
      line(H, 3, 8'h80, 1'b1, 4, 8'h80);
      vs_pulse(1'b1, 1'b0, 4, 9, 2);

      // New threshold now active; line 2 is one pixel short
      frame(4, 2, 8'h80, 1'b1, 4, 8'h90);
      threshold = 8'h80;
      vs_pulse(1'b0, 1'b1, 4, 0, 3);
      frame(4, -1, 8'hC0, 1'b0, 4, 8'h80);
      vs_pulse(1'b1, 1'b0, 4, 0, 3);

      // Reset during line 2 while a pixel is active
      line(H, 0, 8'hC0, 1'b1, 4, 8'h80);
      line(H, 1, 8'hC0, 1'b1, 4, 8'h80);
      repeat (2) px(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      for (int x = 0; x < 3; x++) px(1'b1, 1'b1, 1'b0, 1'b0, 8'hC0, exp_px(1'b1, x, 2, 4, 8'hC0, 8'h80));
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid reset out_edge", out_edge, 8'h00);
      check("mid reset out_de", out_de, 1'b0);
      check("mid reset locked", locked, 1'b0);
      check("mid reset meas_lines", meas_lines, 10'd0);
`ifdef SOBEL_WINDOW_CTRL_STATS_EN
      check("mid reset frame_count", frame_count, 16'd0);
`endif
      repeat (3) @(negedge clk);
      in_de = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Relock needs a full good frame after the first frame start
      vs_pulse(1'b0, 1'b0, 0, 0, 0);
      frame(4, -1, 8'hC0, 1'b0, 4, 8'h80);
      vs_pulse(1'b1, 1'b0, 4, 0, 0);
      frame(4, -1, 8'hC0, 1'b1, 4, 8'h80);
      vs_pulse(1'b1, 1'b0, 4, 12, 1);
      frame(4, -1, 8'hC0, 1'b1, 4, 8'h80);
      vs_pulse(1'b1, 1'b0, 4, 12, 2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
